multicycle_control_unit: RTL and testbench

- Parametrised, sequential successor to the single-cycle opcode decoder for the KGP-miniRISC core.
- Registers the decoded control word, then sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memory that may insert wait states.
- Sits between the instruction register and the datapath; drives the same control signal set, plus PC/IR strobes and memory requests.

---
 rtl/multicycle_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle KGP-miniRISC control unit: registers the decoded control word and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB. Define MCU_PERF_CNT_EN to add retired/stall counters.
module multicycle_control_unit #(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 3,
  parameter int BRH_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               ir_load,
  output logic               pc_write,
  output logic [1:0]         regDst,
  output logic               regWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic [1:0]         memToReg,
  output logic               jumpAddr,
  output logic               lblSel,
  output logic [BRH_W-1:0]   brhSel,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               illegal,
  output logic [2:0]         state_o
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Control word latched on DECODE exit; the is_* flags steer the later phases.
  typedef struct packed {
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic [BRH_W-1:0]   brh_sel;
    logic               jump_addr;
    logic               lbl_sel;
    logic               is_branch;
    logic               is_call;
    logic               is_load;
    logic               is_store;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  cw, dec;
  logic   dec_illegal;
  logic   imem_req_d, dmem_req_d, ir_load_d, pc_write_d;
  logic   reg_write_d, mem_read_d, mem_write_d, illegal_d;

  // Opcode decoder; an illegal opcode yields an all-zero word, which also clears the fields in TRAP.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec         = '0;
    dec_illegal = 1'b0;
    case (opcode[OPC_W-1 -: 2])
      2'b00: begin
        dec.reg_dst = 2'b01;
        dec.alu_op  = opcode[ALUOP_W-1:0];
      end
      2'b01: dec.alu_op = opcode[ALUOP_W-1:0];
      2'b11: begin
        case (opcode[1:0])
          2'b01: begin
            dec.is_load    = 1'b1;
            dec.mem_to_reg = 2'b01;
          end
          2'b10:   dec.is_store = 1'b1;
          default: dec_illegal  = 1'b1;
        endcase
      end
      default: begin
        if (opcode[3]) begin
          dec_illegal = 1'b1;
        end else begin
          dec.is_branch = 1'b1;
          dec.brh_sel   = BRH_W'({1'b1, opcode[2:0]});
          case (opcode[2:0])
            3'b000: dec.jump_addr = 1'b1;
            3'b001: begin
              dec.jump_addr  = 1'b1;
              dec.is_call    = 1'b1;
              dec.reg_dst    = 2'b10;
              dec.mem_to_reg = 2'b10;
            end
            default: dec.lbl_sel = 1'b1;
          endcase
        end
      end
    endcase
    if (dec_illegal) dec = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (cw.is_branch)                state_d = cw.is_call ? S_WB : S_FETCH;
        else if (cw.is_load || cw.is_store) state_d = S_MEM;
        else                             state_d = S_WB;
      end
      S_MEM:    if (dmem_ack) state_d = cw.is_load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are computed from the transition being taken and registered, so each one is
  // high during the cycle that follows its triggering edge (e.g. ir_load right after the ack).
  always_comb begin
    imem_req_d  = (state_d == S_FETCH);
    ir_load_d   = (state_q == S_FETCH) && imem_ack;
    pc_write_d  = ir_load_d || ((state_q == S_DECODE) && !dec_illegal && dec.is_branch);
    dmem_req_d  = (state_d == S_MEM);
    mem_read_d  = (state_d == S_MEM) && cw.is_load;
    mem_write_d = (state_d == S_MEM) && cw.is_store;
    reg_write_d = (state_d == S_WB);
    illegal_d   = illegal || (state_d == S_TRAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cw       <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      ir_load  <= 1'b0;
      pc_write <= 1'b0;
      regWrite <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      if (state_q == S_DECODE) cw <= dec;
      imem_req <= imem_req_d;
      dmem_req <= dmem_req_d;
      ir_load  <= ir_load_d;
      pc_write <= pc_write_d;
      regWrite <= reg_write_d;
      memRead  <= mem_read_d;
      memWrite <= mem_write_d;
      illegal  <= illegal_d;
    end
  end

  assign regDst   = cw.reg_dst;
  assign memToReg = cw.mem_to_reg;
  assign aluOp    = cw.alu_op;
  assign brhSel   = cw.brh_sel;
  assign jumpAddr = cw.jump_addr;
  assign lblSel   = cw.lbl_sel;
  assign state_o  = state_q;

`ifdef MCU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if ((state_d == S_FETCH) &&
          ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)))
        retired_cnt <= retired_cnt + 32'd1;
      if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed test-plan instructions followed by
// random instructions with random wait states, checked cycle by cycle against a phase-level model.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       imem_ack, dmem_ack;
  logic       imem_req, dmem_req, ir_load, pc_write, regWrite, memRead, memWrite;
  logic [1:0] regDst, memToReg;
  logic       jumpAddr, lblSel, illegal;
  logic [3:0] brhSel;
  logic [2:0] aluOp, state_o;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
  int unsigned exp_retired, exp_stall;
`endif

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_load(ir_load), .pc_write(pc_write),
    .regDst(regDst), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .jumpAddr(jumpAddr), .lblSel(lblSel), .brhSel(brhSel),
    .aluOp(aluOp), .illegal(illegal), .state_o(state_o)
`ifdef MCU_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {K_ALU, K_LOAD, K_STORE, K_JUMP, K_CALL, K_BRANCH, K_ILL} kind_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  logic [12:0] exp_fields;
  logic        exp_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] op);
    case (op[5:4])
      2'b00, 2'b01: return K_ALU;
      2'b11: return (op[1:0] == 2'b01) ? K_LOAD : (op[1:0] == 2'b10) ? K_STORE : K_ILL;
      default: begin
        if (op[3])             return K_ILL;
        if (op[2:0] == 3'b000) return K_JUMP;
        if (op[2:0] == 3'b001) return K_CALL;
        return K_BRANCH;
      end
    endcase
  endfunction

  // {regDst, memToReg, aluOp, brhSel, jumpAddr, lblSel} expected after DECODE
  function automatic logic [12:0] ref_fields(input logic [5:0] op, input kind_t k);
    logic [1:0] rd, m2r;
    logic [2:0] alu;
    logic [3:0] brh;
    logic       j, l;
    rd = 2'b00; m2r = 2'b00; alu = 3'b000; brh = 4'b0000; j = 1'b0; l = 1'b0;
    case (k)
      K_ALU: begin
        rd  = (op[5:4] == 2'b00) ? 2'b01 : 2'b00;
        alu = op[2:0];
      end
      K_LOAD: m2r = 2'b01;
      K_JUMP: begin brh = 4'b1000; j = 1'b1; end
      K_CALL: begin brh = 4'b1001; j = 1'b1; rd = 2'b10; m2r = 2'b10; end
      K_BRANCH: begin brh = {1'b1, op[2:0]}; l = 1'b1; end
      default: ;
    endcase
    return {rd, m2r, alu, brh, j, l};
  endfunction

  function automatic logic rbit(input bit tied);
    return tied ? 1'b1 : 1'($urandom);
  endfunction

  // strobes = {imem_req, dmem_req, ir_load, pc_write, regWrite, memRead, memWrite}
  task automatic compare(input logic [2:0] st, input logic [6:0] strobes);
    check("state", 32'(state_o), 32'(st));
    check("strobes", 32'({imem_req, dmem_req, ir_load, pc_write, regWrite, memRead, memWrite}),
          32'(strobes));
    check("fields", 32'({regDst, memToReg, aluOp, brhSel, jumpAddr, lblSel}), 32'(exp_fields));
    check("illegal", 32'(illegal), 32'(exp_illegal));
`ifdef MCU_PERF_CNT_EN
    check("retired_cnt", retired_cnt, exp_retired);
    check("stall_cnt", stall_cnt, exp_stall);
`endif
  endtask

  task automatic step(input logic [2:0] st, input logic [6:0] strobes, input logic iack,
                      input logic dack, input logic [5:0] opc);
    compare(st, strobes);
    opcode   = opc;
    imem_ack = iack;
    dmem_ack = dack;
    @(posedge clk);
    #1;
    cyc++;
`ifdef MCU_PERF_CNT_EN
    if ((strobes[6] && !iack) || (strobes[5] && !dack)) exp_stall++;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_fields  = '0;
    exp_illegal = 1'b0;
`ifdef MCU_PERF_CNT_EN
    exp_retired = 0;
    exp_stall   = 0;
`endif
    compare(3'd0, 7'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    step(3'd0, 7'b0, rbit(1'b0), rbit(1'b0), 6'($urandom));
  endtask

  // One instruction from FETCH entry; an illegal one spends trap_len cycles in TRAP then resets.
  // abort_at >= 0 asserts reset during that MEM cycle.
  task automatic run_instr(input logic [5:0] op, input int iw, input int dw, input bit tied,
                           input int trap_len, input int abort_at);
    kind_t k;
    bit    is_mem;
    k = classify(op);
    if (tied) begin iw = 0; dw = 0; end
    for (int j = 0; j <= iw; j++)
      step(3'd1, 7'b1000000, (j == iw) ? 1'b1 : 1'b0, rbit(tied), 6'($urandom));
    step(3'd2, 7'b0011000, rbit(tied), rbit(tied), op);
    if (k == K_ILL) begin
      exp_fields  = '0;
      exp_illegal = 1'b1;
      for (int j = 0; j < trap_len; j++)
        step(3'd6, 7'b0, rbit(tied), rbit(tied), 6'($urandom));
      do_reset();
      return;
    end
    exp_fields = ref_fields(op, k);
    is_mem     = (k == K_LOAD) || (k == K_STORE);
    step(3'd3, (k == K_JUMP || k == K_CALL || k == K_BRANCH) ? 7'b0001000 : 7'b0,
         rbit(tied), rbit(tied), 6'($urandom));
    if (is_mem) begin
      for (int j = 0; j <= dw; j++) begin
        if (j == abort_at) begin
          compare(3'd4, {2'b01, 3'b000, k == K_LOAD, k == K_STORE});
          do_reset();
          return;
        end
        step(3'd4, {2'b01, 3'b000, k == K_LOAD, k == K_STORE}, rbit(tied),
             (j == dw) ? 1'b1 : 1'b0, 6'($urandom));
      end
    end
    if (k == K_ALU || k == K_LOAD || k == K_CALL)
      step(3'd5, 7'b0000100, rbit(tied), rbit(tied), 6'($urandom));
`ifdef MCU_PERF_CNT_EN
    exp_retired++;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op;
    rst      = 1'b1;
    opcode   = '0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    exp_fields  = '0;
    exp_illegal = 1'b0;
    do_reset();

    run_instr(6'b000000, 0, 0, 1'b1, 0, -1);   // R-type, acks tied high
    run_instr(6'b110001, 0, 3, 1'b0, 0, -1);   // load, dmem_ack 3 cycles late
    run_instr(6'b110010, 1, 2, 1'b0, 0, -1);   // store
    run_instr(6'b100001, 0, 0, 1'b0, 0, -1);   // call
    run_instr(6'b100101, 2, 0, 1'b0, 0, -1);   // conditional branch
    run_instr(6'b100000, 0, 0, 1'b1, 0, -1);   // jump

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1: op = {2'b00, 4'($urandom)};
        2, 3: op = {2'b01, 4'($urandom)};
        4:    op = 6'b110001;
        5:    op = 6'b110010;
        6, 7: op = {3'b100, 3'($urandom)};
        8:    op = 6'b011111;
        default: begin
          case ($urandom_range(0, 2))
            0:       op = 6'b110000;
            1:       op = 6'b110011;
            default: op = {3'b101, 3'($urandom)};
          endcase
        end
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, $urandom_range(1, 5), -1);
    end

    run_instr(6'b110011, 0, 0, 1'b0, 20, -1);  // illegal: 20 cycles of TRAP, then reset
    run_instr(6'b110001, 0, 8, 1'b0, 0, 4);    // reset lands mid-MEM with dmem_req high
    run_instr(6'b011010, 0, 0, 1'b1, 0, -1);   // normal operation resumes after reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
